rnd_server: RTL and testbench

- Shares one 13-bit Fibonacci LFSR between NREQ requesters.
- Round-robin arbitration; each grant runs the LFSR for SHIFTS steps, so every requester gets a fully fresh 13-bit sample.
- Delivers the sample with a one-cycle valid strobe.
- Sits between the game/control logic and the random source; it is the only block allowed to step the LFSR.

---
 rtl/rnd_pkg.sv | 26 ++
 rtl/rnd_lfsr_core.sv | 33 +++
 rtl/rnd_server.sv | 113 +++++++++++
 tb/tb_rnd_server.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnd_pkg.sv
// Shared constants, state encoding and LFSR step function for the random server.
package rnd_pkg;

  localparam int LFSR_W = 13;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h000F;

  // Feedback taps of the 13-bit Fibonacci LFSR.
  localparam int TAP_A = 12;
  localparam int TAP_B = 3;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // One LFSR step: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
    return {l[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/rnd_lfsr_core.sv
// LFSR state register with load and step controls; a zero load value is
// replaced by the seed so the register can never lock up at zero.
module rnd_lfsr_core
  import rnd_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] state;

  // Load has priority over stepping; zero is never written into the register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == {LFSR_W{1'b0}}) ? SEED : load_value;
    end else if (step) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

  assign value = state;

endmodule

// File: rtl/rnd_server.sv
// Round-robin server that hands one fresh LFSR sample to each granted requester.
module rnd_server
  import rnd_pkg::*;
#(
  parameter int                NREQ   = 4,
  parameter int                WIDTH  = LFSR_W,
  parameter int                SHIFTS = 13,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LAST = 4'(SHIFTS - 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     cand;
  logic              any_req;
  logic [3:0]        count;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_post;
  logic              lfsr_step;
  logic              lfsr_load;

  // Search downward so the requester closest after rr_ptr is the one kept.
  always_comb begin
    pick = rr_ptr;
    cand = rr_ptr;
    for (int i = NREQ; i >= 1; i--) begin
      cand = PW'((int'(rr_ptr) + i) % NREQ);
      pick = req[cand] ? cand : pick;
    end
  end

  assign any_req   = |req;
  assign lfsr_load = (state == IDLE) && seed_load;
  assign lfsr_step = (state == SHIFT);
  assign lfsr_post = lfsr_next(lfsr);
  assign busy      = (state != IDLE);

  rnd_lfsr_core #(
    .SEED (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .step       (lfsr_step),
    .load       (lfsr_load),
    .load_value (seed),
    .value      (lfsr)
  );

  // Arbitration / service FSM with registered grant, sample and strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      count     <= 4'd0;
      gnt       <= {NREQ{1'b0}};
      rnd       <= {WIDTH{1'b0}};
      rnd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rnd_valid <= 1'b0;
          // A seed load wins this cycle; a pending request is served next cycle.
          if (seed_load) begin
            state <= IDLE;
          end else if (any_req) begin
            gnt    <= ONE << pick;
            rr_ptr <= pick;
            count  <= 4'd0;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          count <= count + 4'd1;
          if (count == LAST) begin
            rnd       <= lfsr_post;
            rnd_valid <= 1'b1;
            state     <= DELIVER;
          end else begin
            state <= SHIFT;
          end
        end
        DELIVER: begin
          gnt       <= {NREQ{1'b0}};
          rnd_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt       <= {NREQ{1'b0}};
          rnd_valid <= 1'b0;
          count     <= 4'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_server.sv
// Self-checking bench for rnd_server against a behavioural model of the
// LFSR sample sequence and round-robin arbitration.
module tb_rnd_server;

  localparam logic [12:0] SEED_V = 13'h000F;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        seed_load;
  logic [12:0] seed;
  logic [3:0]  gnt;
  logic        busy;
  logic        rnd_valid;
  logic [12:0] rnd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] m_lfsr;
  int          m_rr;

  always #5 clock = ~clock;

  rnd_server #(
    .NREQ   (4),
    .WIDTH  (13),
    .SHIFTS (13),
    .SEED   (SEED_V)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .seed_load (seed_load),
    .seed      (seed),
    .gnt       (gnt),
    .busy      (busy),
    .rnd_valid (rnd_valid),
    .rnd       (rnd)
  );

  function automatic logic [12:0] m_step(input logic [12:0] l);
    return {l[11:0], l[12] ^ l[3] ^ l[2] ^ l[0]};
  endfunction

  // Sample handed out by one service: thirteen steps from the current state.
  function automatic logic [12:0] m_sample(input logic [12:0] l);
    logic [12:0] v;
    v = l;
    for (int k = 0; k < 13; k++) v = m_step(v);
    return v;
  endfunction

  function automatic int m_pick(input logic [3:0] r, input int rr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (rnd_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0000; seed_load = 1'b0; seed = 13'h0000;
    #12;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (rnd !== 13'h0000) begin n_fail++; $display("FAIL reset_rnd: got %h want 0000", rnd); end
    n_checks++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b1;
    m_lfsr = SEED_V;
    m_rr = 3;
  endtask

  task automatic test_single();
    int n;
    logic [12:0] exp;
    @(negedge clock);
    req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    exp = m_sample(m_lfsr); m_lfsr = exp; m_rr = 0;
    wait_valid(n);
    n_checks++; if (n != 13) begin n_fail++; $display("FAIL single_latency: got %0d want 13", n); end
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL single_rnd: got %h want %h", rnd, exp); end
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt_held: got %b want 0001", gnt); end
    @(negedge clock);
    n_checks++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL single_strobe_len: got %b want 0", rnd_valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_clear: got %b want 0000", gnt); end
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL single_rnd_hold: got %h want %h", rnd, exp); end
  endtask

  task automatic test_round_robin();
    int n, idx;
    logic [12:0] exp, prev;
    prev = rnd;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      idx = m_pick(4'b1111, m_rr); m_rr = idx;
      n_checks++; if (gnt !== onehot(idx)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", s, gnt, onehot(idx)); end
      exp = m_sample(m_lfsr); m_lfsr = exp;
      wait_valid(n);
      n_checks++; if (n != 13) begin n_fail++; $display("FAIL rr_latency[%0d]: got %0d want 13", s, n); end
      n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL rr_rnd[%0d]: got %h want %h", s, rnd, exp); end
      n_checks++; if (rnd === prev) begin n_fail++; $display("FAIL rr_fresh[%0d]: got %h, previous %h", s, rnd, prev); end
      prev = rnd;
      @(negedge clock);
      if (s == 4) req = 4'b0000;
      n_checks++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL rr_strobe_len[%0d]: got %b want 0", s, rnd_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got busy %b want 0", s, busy); end
    end
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_zero_seed();
    int n;
    logic [12:0] exp;
    seed_load = 1'b1; seed = 13'h0000;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr = SEED_V;
    req = 4'b0100;
    @(negedge clock);
    req = 4'b0000;
    m_rr = m_pick(4'b0100, m_rr);
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL zseed_gnt: got %b want 0100", gnt); end
    exp = m_sample(m_lfsr); m_lfsr = exp;
    wait_valid(n);
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL zseed_rnd: got %h want %h", rnd, exp); end
    @(negedge clock);
  endtask

  task automatic test_seed_priority();
    int n;
    logic [12:0] s, exp;
    s = 13'($urandom_range(1, 8191));
    seed_load = 1'b1; seed = s; req = 4'b0010;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr = s;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL prio_no_gnt: got %b want 0000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b want 0", busy); end
    @(negedge clock);
    req = 4'b0000;
    m_rr = m_pick(4'b0010, m_rr);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL prio_gnt: got %b want 0010", gnt); end
    exp = m_sample(m_lfsr); m_lfsr = exp;
    repeat (3) @(negedge clock);
    seed_load = 1'b1; seed = ~s;
    @(negedge clock);
    seed_load = 1'b0;
    wait_valid(n);
    n_checks++; if (n != 9) begin n_fail++; $display("FAIL prio_latency: got %0d want 9", n); end
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL prio_ignored_load: got %h want %h", rnd, exp); end
    @(negedge clock);
  endtask

  task automatic test_drop();
    int n;
    logic [12:0] exp;
    req = 4'b1000;
    @(negedge clock);
    m_rr = m_pick(4'b1000, m_rr);
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_gnt: got %b want 1000", gnt); end
    exp = m_sample(m_lfsr); m_lfsr = exp;
    repeat (2) @(negedge clock);
    req = 4'b0000;
    wait_valid(n);
    n_checks++; if (n != 11) begin n_fail++; $display("FAIL drop_latency: got %0d want 11", n); end
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL drop_rnd: got %h want %h", rnd, exp); end
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_gnt_held: got %b want 1000", gnt); end
    @(negedge clock);
    req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    m_rr = m_pick(4'b0001, m_rr);
    exp = m_sample(m_lfsr); m_lfsr = exp;
    wait_valid(n);
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL drop_next_rnd: got %h want %h", rnd, exp); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [12:0] exp;
    req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rmid_gnt: got %b want 0000", gnt); end
    n_checks++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", rnd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (rnd !== 13'h0000) begin n_fail++; $display("FAIL rmid_rnd: got %h want 0000", rnd); end
    @(negedge clock);
    reset = 1'b1;
    m_lfsr = SEED_V; m_rr = 3;
    req = 4'b0001;
    @(negedge clock);
    req = 4'b0000;
    m_rr = 0;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_regnt: got %b want 0001", gnt); end
    exp = m_sample(m_lfsr); m_lfsr = exp;
    wait_valid(n);
    n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL rmid_rnd_after: got %h want %h", rnd, exp); end
    @(negedge clock);
  endtask

  task automatic test_random();
    int n, idx;
    logic [3:0] r;
    logic [12:0] s, exp;
    logic do_seed;
    for (int it = 0; it < 16; it++) begin
      r = 4'($urandom_range(1, 15));
      do_seed = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) == 0) ? 13'h0000 : 13'($urandom);
      req = r; seed_load = do_seed; seed = s;
      if (do_seed) begin
        m_lfsr = (s == 13'h0000) ? SEED_V : s;
        @(negedge clock);
        seed_load = 1'b0;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rand_seed_gnt[%0d]: got %b want 0000", it, gnt); end
      end
      @(negedge clock);
      req = 4'b0000;
      idx = m_pick(r, m_rr); m_rr = idx;
      n_checks++; if (gnt !== onehot(idx)) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b (req %b)", it, gnt, onehot(idx), r); end
      exp = m_sample(m_lfsr); m_lfsr = exp;
      wait_valid(n);
      n_checks++; if (n != 13) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 13", it, n); end
      n_checks++; if (rnd !== exp) begin n_fail++; $display("FAIL rand_rnd[%0d]: got %h want %h", it, rnd, exp); end
      @(negedge clock);
      n_checks++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL rand_strobe_len[%0d]: got %b want 0", it, rnd_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_seed();
    test_seed_priority();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
